// File: rtl/alu_sequencer_if.sv
// Bundle of all non-clock signals of alu_sequencer: decode handshake, register
// load/debug ports, ALU issue port and retire status.
interface alu_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
);
  localparam int AW = $clog2(NREGS);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [AW-1:0]    in_rd;
  logic [AW-1:0]    in_rs1;
  logic [AW-1:0]    in_rs2;
  logic             ld_en;
  logic [AW-1:0]    ld_addr;
  logic [WIDTH-1:0] ld_data;
  logic             alu_active;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_y;
  logic             alu_carry;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] result;
  logic             carry_flag;
  logic             zero_flag;
  logic [AW-1:0]    dbg_addr;
  logic [WIDTH-1:0] dbg_data;

  // Sequencer side
  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2,
    input  ld_en, ld_addr, ld_data,
    input  alu_y, alu_carry, dbg_addr,
    output in_ready, alu_active, alu_op, alu_a, alu_b,
    output done, err, result, carry_flag, zero_flag, dbg_data
  );

  // Decode / ALU / debug environment side
  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2,
    output ld_en, ld_addr, ld_data,
    output alu_y, alu_carry, dbg_addr,
    input  in_ready, alu_active, alu_op, alu_a, alu_b,
    input  done, err, result, carry_flag, zero_flag, dbg_data
  );
endinterface

// File: rtl/alu_sequencer.sv
// Two-state issue sequencer for a combinational ALU: reads operands from a local
// register file, presents them to the ALU for one cycle and writes the result back.
module alu_sequencer #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
) (
  input  logic            clk,
  input  logic            rst,
  alu_sequencer_if.slave  bus
);
  localparam int AW = $clog2(NREGS);
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [2:0]       op_q;
  logic [AW-1:0]    rd_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             active_q;
  logic             done_q;
  logic             err_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             zero_q;

  logic             in_legal_d;
  logic             op_legal_d;

  // Opcodes 11x are illegal.
  assign in_legal_d = (bus.in_op[2:1] != 2'b11);
  assign op_legal_d = (op_q[2:1] != 2'b11);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      // NOTE: the register file is architecturally visible and must read as zero
      // after reset, so it is cleared here rather than left to power-up values.
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      // External load first so that a same-edge retire to the same slot wins.
      if (bus.ld_en) regs_q[bus.ld_addr] <= bus.ld_data;
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            op_q     <= bus.in_op;
            rd_q     <= bus.in_rd;
            a_q      <= regs_q[bus.in_rs1];
            b_q      <= regs_q[bus.in_rs2];
            active_q <= in_legal_d;
            state_q  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          active_q <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= S_IDLE;
          if (op_legal_d) begin
            regs_q[rd_q] <= bus.alu_y;
            result_q     <= bus.alu_y;
            zero_q       <= (bus.alu_y == '0);
            if (op_q == OP_ADD || op_q == OP_SUB) carry_q <= bus.alu_carry;
          end else begin
            err_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (state_q == S_IDLE);
  assign bus.alu_active = active_q;
  assign bus.alu_op     = op_q;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.result     = result_q;
  assign bus.carry_flag = carry_q;
  assign bus.zero_flag  = zero_q;
  assign bus.dbg_data   = regs_q[bus.dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: transaction-level reference model,
// per-cycle compare process, directed scenarios with literal expectations, random traffic.
module tb_alu_sequencer;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int AW = 2;

  logic clk;
  logic rst;
  bit   junk_c;
  bit   chk_en;
  int   tests;
  int   fails;

  alu_sequencer_if #(.WIDTH(W), .NREGS(N)) bus ();

  alu_sequencer #(.WIDTH(W), .NREGS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Combinational ALU stand-in; carry on non-arithmetic ops is deliberately junk.
  always_comb begin
    bus.alu_y     = '0;
    bus.alu_carry = junk_c;
    case (bus.alu_op)
      3'd0: {bus.alu_carry, bus.alu_y} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      3'd1: begin
        bus.alu_y     = bus.alu_a - bus.alu_b;
        bus.alu_carry = (bus.alu_a < bus.alu_b);
      end
      3'd2: bus.alu_y = bus.alu_a & bus.alu_b;
      3'd3: bus.alu_y = bus.alu_a | bus.alu_b;
      3'd4: bus.alu_y = ~bus.alu_a;
      3'd5: bus.alu_y = bus.alu_a;
      default: bus.alu_y = 8'hEE;
    endcase
  end

  // ---------------- reference model ----------------
  logic [W-1:0]  m_regs [N];
  bit            m_busy, m_active, m_done, m_err, m_carry, m_zero;
  logic [2:0]    m_op;
  logic [AW-1:0] m_rd;
  logic [W-1:0]  m_a, m_b, m_result;

  function automatic bit legal(logic [2:0] op);
    return op < 3'd6;
  endfunction

  // Returns {carry, y} from the architectural definition of each opcode.
  function automatic logic [W:0] alu_ref(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
    int ia, ib, s;
    ia = int'(a);
    ib = int'(b);
    case (op)
      3'd0: begin s = ia + ib;       return {s > 255, s[7:0]}; end
      3'd1: begin s = ia - ib + 256; return {ia < ib, s[7:0]}; end
      3'd2: return {1'b0, a & b};
      3'd3: return {1'b0, a | b};
      3'd4: return {1'b0, ~a};
      default: return {1'b0, a};
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < N; i++) m_regs[i] = '0;
        m_busy = 0; m_active = 0; m_done = 0; m_err = 0;
        m_carry = 0; m_zero = 0; m_result = '0;
        m_op = '0; m_rd = '0; m_a = '0; m_b = '0;
      end else begin
        bit           retire, accept;
        logic [W-1:0] na, nb;
        logic [W:0]   r;
        retire = m_busy;
        accept = !m_busy && bus.in_valid;
        na = m_regs[bus.in_rs1];
        nb = m_regs[bus.in_rs2];
        if (bus.ld_en) m_regs[bus.ld_addr] = bus.ld_data;
        m_done = retire;
        m_err  = retire && !legal(m_op);
        if (retire && legal(m_op)) begin
          r = alu_ref(m_op, m_a, m_b);
          m_regs[m_rd] = r[W-1:0];
          m_result     = r[W-1:0];
          m_zero       = (r[W-1:0] == 0);
          if (m_op == 3'd0 || m_op == 3'd1) m_carry = r[W];
        end
        if (accept) begin
          m_op = bus.in_op; m_rd = bus.in_rd; m_a = na; m_b = nb;
        end
        m_active = accept && legal(bus.in_op);
        m_busy   = accept;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready",   32'(bus.in_ready),   32'(!m_busy));
      check("alu_active", 32'(bus.alu_active), 32'(m_active));
      check("alu_op",     32'(bus.alu_op),     32'(m_op));
      check("alu_a",      32'(bus.alu_a),      32'(m_a));
      check("alu_b",      32'(bus.alu_b),      32'(m_b));
      check("done",       32'(bus.done),       32'(m_done));
      check("err",        32'(bus.err),        32'(m_err));
      check("result",     32'(bus.result),     32'(m_result));
      check("carry_flag", 32'(bus.carry_flag), 32'(m_carry));
      check("zero_flag",  32'(bus.zero_flag),  32'(m_zero));
      check("dbg_data",   32'(bus.dbg_data),   32'(m_regs[bus.dbg_addr]));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] addr, input logic [W-1:0] data);
    bus.ld_en = 1'b1; bus.ld_addr = addr; bus.ld_data = data;
    cyc();
    bus.ld_en = 1'b0;
  endtask

  task automatic dbg(input string name, input logic [AW-1:0] addr, input logic [W-1:0] exp);
    bus.dbg_addr = addr;
    #1;
    check(name, 32'(bus.dbg_data), 32'(exp));
  endtask

  // Accept at edge T, check ISSUE cycle, return positioned 1 time unit into T+2.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [AW-1:0] rd,
                        input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
    bus.in_valid = 1'b1; bus.in_op = op;
    bus.in_rd = rd; bus.in_rs1 = rs1; bus.in_rs2 = rs2;
    cyc();
    bus.in_valid = 1'b0;
    check({tag, "_active_t1"}, 32'(bus.alu_active), 32'(op < 3'd6));
    check({tag, "_ready_t1"},  32'(bus.in_ready),   32'd0);
    check({tag, "_done_t1"},   32'(bus.done),       32'd0);
    cyc();
    check({tag, "_done_t2"},   32'(bus.done),       32'd1);
    check({tag, "_err_t2"},    32'(bus.err),        32'(op >= 3'd6));
    check({tag, "_active_t2"}, 32'(bus.alu_active), 32'd0);
    check({tag, "_ready_t2"},  32'(bus.in_ready),   32'd1);
  endtask

  initial begin
    tests = 0; fails = 0; chk_en = 0; junk_c = 0;
    rst = 1'b1;
    bus.in_valid = 0; bus.in_op = '0; bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
    bus.ld_en = 0; bus.ld_addr = '0; bus.ld_data = '0; bus.dbg_addr = '0;
    repeat (3) cyc();
    rst = 1'b0;
    chk_en = 1;
    check("rst_ready",  32'(bus.in_ready),   32'd1);
    check("rst_active", 32'(bus.alu_active), 32'd0);
    check("rst_done",   32'(bus.done),       32'd0);
    check("rst_result", 32'(bus.result),     32'd0);
    check("rst_alu_a",  32'(bus.alu_a),      32'd0);
    check("rst_carry",  32'(bus.carry_flag), 32'd0);

    // 1: ADD with carry out
    load(2'd0, 8'hF0); load(2'd1, 8'h20);
    run_op("t1", 3'd0, 2'd2, 2'd0, 2'd1);
    check("t1_result", 32'(bus.result),     32'h10);
    check("t1_carry",  32'(bus.carry_flag), 32'd1);
    check("t1_zero",   32'(bus.zero_flag),  32'd0);
    dbg("t1_r2", 2'd2, 8'h10);

    // 2: SUB to zero, then SUB with borrow
    load(2'd0, 8'h05); load(2'd1, 8'h05);
    run_op("t2a", 3'd1, 2'd3, 2'd0, 2'd1);
    check("t2a_result", 32'(bus.result),     32'h00);
    check("t2a_zero",   32'(bus.zero_flag),  32'd1);
    check("t2a_carry",  32'(bus.carry_flag), 32'd0);
    load(2'd0, 8'h00); load(2'd1, 8'h01);
    run_op("t2b", 3'd1, 2'd3, 2'd0, 2'd1);
    check("t2b_result", 32'(bus.result),     32'hFF);
    check("t2b_carry",  32'(bus.carry_flag), 32'd1);

    // 3: AND leaves carry alone even with ALU carry low
    junk_c = 0;
    load(2'd0, 8'h0F); load(2'd1, 8'hF0);
    run_op("t3", 3'd2, 2'd2, 2'd0, 2'd1);
    check("t3_result", 32'(bus.result),     32'h00);
    check("t3_zero",   32'(bus.zero_flag),  32'd1);
    check("t3_carry",  32'(bus.carry_flag), 32'd1);

    // 4: illegal op retires with err and no side effects
    run_op("t4", 3'b110, 2'd1, 2'd0, 2'd0);
    check("t4_result", 32'(bus.result),     32'h00);
    check("t4_carry",  32'(bus.carry_flag), 32'd1);
    check("t4_zero",   32'(bus.zero_flag),  32'd1);
    dbg("t4_r1", 2'd1, 8'hF0);

    // 5: reset during ISSUE
    bus.in_valid = 1'b1; bus.in_op = 3'd0; bus.in_rd = 2'd0; bus.in_rs1 = 2'd1; bus.in_rs2 = 2'd1;
    cyc();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("t5_ready",  32'(bus.in_ready),   32'd1);
    check("t5_done",   32'(bus.done),       32'd0);
    check("t5_carry",  32'(bus.carry_flag), 32'd0);
    check("t5_zero",   32'(bus.zero_flag),  32'd0);
    check("t5_result", 32'(bus.result),     32'd0);
    for (int i = 0; i < N; i++) dbg("t5_reg", AW'(i), 8'h00);

    // 6: back-to-back MV chain with in_valid held; load collides with last retire
    load(2'd0, 8'h11); load(2'd1, 8'h22); load(2'd2, 8'h33);
    bus.in_valid = 1'b1; bus.in_op = 3'd5;
    for (int k = 0; k < 3; k++) begin
      bus.in_rd = AW'(k + 1); bus.in_rs1 = AW'(k); bus.in_rs2 = AW'(k);
      cyc();
      check("t6_ready_issue", 32'(bus.in_ready), 32'd0);
      check("t6_done_issue",  32'(bus.done),     32'd0);
      if (k == 2) begin
        bus.ld_en = 1'b1; bus.ld_addr = 2'd3; bus.ld_data = 8'hAA;
      end
      cyc();
      bus.ld_en = 1'b0;
      check("t6_done_retire",  32'(bus.done),   32'd1);
      check("t6_ready_retire", 32'(bus.in_ready), 32'd1);
      check("t6_result",       32'(bus.result), 32'h11);
    end
    bus.in_valid = 1'b0;
    dbg("t6_r2", 2'd2, 8'h11);
    dbg("t6_r3", 2'd3, 8'h11);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      bus.in_valid = ($urandom_range(0, 1) == 1);
      bus.in_op    = 3'($urandom_range(0, 7));
      bus.in_rd    = AW'($urandom_range(0, N - 1));
      bus.in_rs1   = AW'($urandom_range(0, N - 1));
      bus.in_rs2   = AW'($urandom_range(0, N - 1));
      bus.ld_en    = ($urandom_range(0, 3) == 0);
      bus.ld_addr  = AW'($urandom_range(0, N - 1));
      bus.ld_data  = W'($urandom_range(0, 255));
      bus.dbg_addr = AW'($urandom_range(0, N - 1));
      junk_c       = ($urandom_range(0, 1) == 1);
      rst          = ($urandom_range(0, 63) == 0);
      cyc();
    end
    rst = 1'b0; bus.in_valid = 1'b0; bus.ld_en = 1'b0;
    repeat (3) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
